run_sequencer: RTL and testbench
================================

Name: run_sequencer

Overview:
Sequencer that drives the processor core's Start/Ack handshake to run NPROG programs back-to-back. It hands data memory to the core only while a program runs. It measures the cycles each program takes and enforces a watchdog timeout. It sits between the testbench/host and the core top level.

Parameters:
NPROG, 3, number of programs run per sequence (1..16)
CW, 16, width of cycle counters
START_CYC, 2, cycles CoreStart is held high per launch (>=1)
TIMEOUT, 16'd4000, max cycles per program before fault (<2^CW)

Ports:
Clk  in  1  clock, posedge
Reset  in  1  synchronous, active-low reset
Go  in  1  request a sequence; sampled only in IDLE
Abort  in  1  leave FAULT/DONE back to IDLE
CoreStart  out  1  to core Start; resets core PC/cycle count
CoreAck  in  1  core done flag (level, combinational from halt opcode)
ProgIdx  out  4  program number currently launched/running
MemOwner  out  1  1 = core owns data memory, 0 = host
Busy  out  1  high in LAUNCH/RUN/REPORT/NEXT
RunValid  out  1  one-cycle pulse: RunCycles/ProgIdx valid
RunCycles  out  CW  cycles of the program just finished
Done  out  1  all NPROG programs completed
Fault  out  1  watchdog expired
TotalCycles  out  CW  saturating sum of RunCycles over the sequence

Behaviour:
- Reset (Reset==0 at posedge): state IDLE; all outputs 0; counters 0. Reset is honoured in every state, including mid-run; CoreStart drops the next cycle.
- IDLE: MemOwner=0. Go==1 -> LAUNCH, ProgIdx<=0, TotalCycles<=0.
- LAUNCH: CoreStart=1, MemOwner=1, held for exactly START_CYC cycles. CoreAck is ignored here because the previous halt may still be visible. Then -> RUN, run counter<=0.
- RUN: CoreStart=0, MemOwner=1. The run counter increments every cycle CoreAck==0.
  - On the first cycle with CoreAck==1: capture RunCycles<=counter, -> REPORT. RunCycles is the number of RUN cycles before Ack. Ack in the first RUN cycle gives 0.
  - If the counter reaches TIMEOUT with CoreAck still 0: -> FAULT. RunCycles<=TIMEOUT and no RunValid is issued.
- REPORT: one cycle. RunValid=1, MemOwner=1. TotalCycles<=TotalCycles+RunCycles, saturating at all-ones. -> NEXT.
- NEXT: one cycle, MemOwner=0.
  - If ProgIdx==NPROG-1: -> DONE.
  - Else ProgIdx<=ProgIdx+1 and -> LAUNCH.
- DONE: Done=1, MemOwner=0; ProgIdx, RunCycles and TotalCycles are held. Abort or Go -> IDLE; Go here does not start a new sequence until seen again in IDLE.
- FAULT: Fault=1, MemOwner=0, CoreStart=0; all values held. Only Abort or Reset leave it (to IDLE). Go is ignored.
- Abort in LAUNCH/RUN/REPORT/NEXT: ignored. Runs are aborted only by Reset.
- All outputs are registered (Moore). Per-program latency Go->RunValid = 1 + START_CYC + runlen + 1 cycles.
- ProgIdx wrap: never exceeds NPROG-1; no wrap-around.

Test Plan:
- Basic: NPROG=3, START_CYC=2; Go 1 cycle; core model Acks after 10, 5, 0 RUN cycles -> RunValid pulses with RunCycles 10, 5, 0 and ProgIdx 0, 1, 2; TotalCycles=15; Done=1; CoreStart high exactly 2 cycles per launch.
- Stale Ack: CoreAck held high through LAUNCH, dropped on the first RUN cycle, reasserted after 7 cycles -> RunCycles=7, no early REPORT.
- Timeout: TIMEOUT=20, CoreAck never asserts -> Fault=1 exactly 20 cycles after RUN entry; RunValid never pulses; Go ignored; Abort -> IDLE, all flags 0.
- Reset mid-run: drive Reset=0 in RUN of program 1 -> next cycle state IDLE, CoreStart=0, MemOwner=0, ProgIdx=0, TotalCycles=0.
- Saturation: CW=8, runs of 200 and 100 cycles -> TotalCycles=255.
- Ownership: MemOwner=1 exactly during LAUNCH/RUN/REPORT; 0 in IDLE, NEXT, DONE and FAULT.

Source files
------------

// File: rtl/run_sequencer_if.sv
// Host/core-facing signal bundle for run_sequencer. The sequencer side is
// the master; the host/core model side is the slave.
interface run_sequencer_if #(
  parameter int CW = 16
);
  logic          Go;
  logic          Abort;
  logic          CoreStart;
  logic          CoreAck;
  logic [3:0]    ProgIdx;
  logic          MemOwner;
  logic          Busy;
  logic          RunValid;
  logic [CW-1:0] RunCycles;
  logic          Done;
  logic          Fault;
  logic [CW-1:0] TotalCycles;

  modport master (
    input  Go, Abort, CoreAck,
    output CoreStart, ProgIdx, MemOwner, Busy, RunValid, RunCycles,
           Done, Fault, TotalCycles
  );

  modport slave (
    output Go, Abort, CoreAck,
    input  CoreStart, ProgIdx, MemOwner, Busy, RunValid, RunCycles,
           Done, Fault, TotalCycles
  );
endinterface

// File: rtl/run_sequencer.sv
// Launches NPROG core programs back-to-back via Start/Ack, measures each run,
// accumulates a saturating total and trips a watchdog on runaway programs.
module run_sequencer #(
  parameter int NPROG     = 3,
  parameter int CW        = 16,
  parameter int START_CYC = 2,
  parameter int TIMEOUT   = 4000
) (
  input logic             Clk,
  input logic             Reset,
  run_sequencer_if.master bus
);
  localparam int LW = (START_CYC > 1) ? $clog2(START_CYC) : 1;

  typedef enum logic [2:0] {
    IDLE, LAUNCH, RUN, REPORT, NEXT, DONE, FAULT
  } state_t;

  state_t        state;
  logic [LW-1:0] launch_cnt;
  logic [CW-1:0] run_cnt;
  logic          core_start;
  logic [3:0]    prog_idx;
  logic          mem_owner;
  logic          busy;
  logic          run_valid;
  logic [CW-1:0] run_cycles;
  logic          done;
  logic          fault;
  logic [CW-1:0] total_cycles;
  logic [CW:0]   total_sum;

  assign total_sum = {1'b0, total_cycles} + {1'b0, run_cycles};

  // Outputs are assigned alongside the transition into each state so they
  // come straight from flops.
  always_ff @(posedge Clk) begin
    if (!Reset) begin
      state        <= IDLE;
      launch_cnt   <= '0;
      run_cnt      <= '0;
      core_start   <= 1'b0;
      prog_idx     <= '0;
      mem_owner    <= 1'b0;
      busy         <= 1'b0;
      run_valid    <= 1'b0;
      run_cycles   <= '0;
      done         <= 1'b0;
      fault        <= 1'b0;
      total_cycles <= '0;
    end else begin
      run_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.Go) begin
            state        <= LAUNCH;
            prog_idx     <= '0;
            total_cycles <= '0;
            launch_cnt   <= '0;
            core_start   <= 1'b1;
            mem_owner    <= 1'b1;
            busy         <= 1'b1;
          end
        end
        LAUNCH: begin
          // A halt left over from the previous program may still show on
          // CoreAck here, so it is not looked at until RUN.
          if (launch_cnt == LW'(START_CYC - 1)) begin
            state      <= RUN;
            core_start <= 1'b0;
            run_cnt    <= '0;
          end else begin
            launch_cnt <= launch_cnt + LW'(1);
          end
        end
        RUN: begin
          if (bus.CoreAck) begin
            state      <= REPORT;
            run_cycles <= run_cnt;
            run_valid  <= 1'b1;
          end else if (run_cnt == CW'(TIMEOUT - 1)) begin
            state      <= FAULT;
            run_cycles <= CW'(TIMEOUT);
            fault      <= 1'b1;
            mem_owner  <= 1'b0;
            busy       <= 1'b0;
          end else begin
            run_cnt <= run_cnt + CW'(1);
          end
        end
        REPORT: begin
          state        <= NEXT;
          mem_owner    <= 1'b0;
          total_cycles <= total_sum[CW] ? '1 : total_sum[CW-1:0];
        end
        NEXT: begin
          if (prog_idx == 4'(NPROG - 1)) begin
            state <= DONE;
            done  <= 1'b1;
            busy  <= 1'b0;
          end else begin
            state      <= LAUNCH;
            prog_idx   <= prog_idx + 4'd1;
            launch_cnt <= '0;
            core_start <= 1'b1;
            mem_owner  <= 1'b1;
          end
        end
        DONE: begin
          if (bus.Abort || bus.Go) begin
            state <= IDLE;
            done  <= 1'b0;
          end
        end
        FAULT: begin
          if (bus.Abort) begin
            state <= IDLE;
            fault <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.CoreStart   = core_start;
  assign bus.ProgIdx     = prog_idx;
  assign bus.MemOwner    = mem_owner;
  assign bus.Busy        = busy;
  assign bus.RunValid    = run_valid;
  assign bus.RunCycles   = run_cycles;
  assign bus.Done        = done;
  assign bus.Fault       = fault;
  assign bus.TotalCycles = total_cycles;
endmodule

// File: tb/tb_run_sequencer.sv
// Randomized scoreboard bench for run_sequencer with a behavioural core model
// and a sequence-level reference model of the expected reports.
module tb_run_sequencer;
  localparam int NPROG     = 3;
  localparam int CW        = 8;
  localparam int START_CYC = 2;
  localparam int TIMEOUT   = 210;
  localparam int MAXV      = 255;
  localparam int NEVER     = 100000;
  localparam int WAIT_LIM  = NPROG * (TIMEOUT + START_CYC + 4) + 20;

  typedef struct {
    int kind;   // 0 = run report, 1 = sequence done, 2 = watchdog fault
    int idx;
    int cyc;
  } ev_t;

  typedef struct {
    int len;
    bit stale;
  } job_t;

  logic clk = 1'b0;
  logic reset;
  logic rst_at_edge = 1'b0;
  int   checks = 0;
  int   errors = 0;
  ev_t  exp_q[$];
  job_t job_q[$];

  run_sequencer_if #(.CW(CW)) bus ();

  run_sequencer #(
    .NPROG(NPROG), .CW(CW), .START_CYC(START_CYC), .TIMEOUT(TIMEOUT)
  ) dut (
    .Clk(clk),
    .Reset(reset),
    .bus(bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) rst_at_edge <= reset;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference model: each program either reports its run length or, if it
  // would reach the watchdog limit, faults and ends the sequence.
  task automatic push_expected(input int lens[NPROG]);
    int total = 0;
    for (int i = 0; i < NPROG; i++) begin
      if (lens[i] >= TIMEOUT) begin
        exp_q.push_back(ev_t'{2, i, TIMEOUT});
        return;
      end
      exp_q.push_back(ev_t'{0, i, lens[i]});
      total = (total + lens[i] > MAXV) ? MAXV : total + lens[i];
    end
    exp_q.push_back(ev_t'{1, NPROG - 1, total});
  endtask

  task automatic start_seq(input int lens[NPROG], input bit stale[NPROG]);
    for (int i = 0; i < NPROG; i++) job_q.push_back(job_t'{lens[i], stale[i]});
    push_expected(lens);
    @(negedge clk);
    bus.Go = 1'b1;
    @(negedge clk);
    bus.Go = 1'b0;
  endtask

  task automatic wait_end();
    int  n  = 0;
    bit  ok = 1'b0;
    while (n < WAIT_LIM) begin
      @(negedge clk);
      if (bus.Done || bus.Fault) begin
        ok = 1'b1;
        break;
      end
      n++;
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL wait_end: no Done/Fault within %0d cycles", WAIT_LIM);
    end
  endtask

  task automatic run_seq(input int lens[NPROG], input bit stale[NPROG], input bit abort_mid);
    start_seq(lens, stale);
    if (abort_mid) begin
      repeat ($urandom_range(1, 5)) @(negedge clk);
      bus.Abort = 1'b1;
      @(negedge clk);
      bus.Abort = 1'b0;
      chk("abort_ignored_busy", bus.Busy, 1);
    end
    wait_end();
  endtask

  task automatic leave_done(input bit use_go);
    chk("done_flag", bus.Done, 1);
    if (use_go) bus.Go = 1'b1;
    else        bus.Abort = 1'b1;
    @(negedge clk);
    bus.Go    = 1'b0;
    bus.Abort = 1'b0;
    chk("done_exit", bus.Done, 0);
    @(negedge clk);
    chk("idle_after_done", bus.Busy, 0);
  endtask

  // Core model: Start resets it; after Start falls it halts (Ack level) once
  // its program length in RUN cycles has elapsed.
  initial begin
    job_t cur = '{NEVER, 1'b0};
    int   run_j = 0;
    bit   start_seen = 1'b0;
    bus.CoreAck = 1'b0;
    forever begin
      @(negedge clk);
      if (bus.CoreStart) begin
        if (!start_seen) cur = (job_q.size() != 0) ? job_q.pop_front() : job_t'{NEVER, 1'b0};
        run_j = 0;
        bus.CoreAck = cur.stale;
      end else begin
        if (run_j < NEVER) run_j++;
        bus.CoreAck = (run_j > cur.len);
      end
      start_seen = bus.CoreStart;
    end
  end

  // Monitor: pops the scoreboard on every reported event and checks the
  // per-cycle launch width, memory ownership and busy flag.
  initial begin
    bit   prev_start = 1'b0, prev_done = 1'b0, prev_fault = 1'b0, prev_valid = 1'b0;
    bit   in_run = 1'b0;
    int   hi_cnt = 0, since = 0;
    ev_t  e;
    logic exp_own, exp_busy;
    forever begin
      @(negedge clk);
      if (prev_start && !bus.CoreStart) since = 0;
      else since++;

      if (prev_start && !bus.CoreStart && rst_at_edge) in_run = 1'b1;
      if (bus.RunValid || bus.Fault || !rst_at_edge) in_run = 1'b0;

      if (bus.CoreStart) hi_cnt++;
      else if (hi_cnt > 0) begin
        chk("core_start_width", hi_cnt, START_CYC);
        hi_cnt = 0;
      end

      exp_own  = bus.CoreStart || in_run || bus.RunValid;
      exp_busy = exp_own || (prev_valid && rst_at_edge);
      chk("mem_owner", bus.MemOwner, exp_own);
      chk("busy", bus.Busy, exp_busy);

      if (bus.RunValid) begin
        if (exp_q.size() == 0 || exp_q[0].kind != 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_run_valid: prog=%0d cycles=%0d, no report expected",
                   bus.ProgIdx, bus.RunCycles);
        end else begin
          e = exp_q.pop_front();
          $display("run    prog=%0d cycles=%0d (expect prog=%0d cycles=%0d)",
                   bus.ProgIdx, bus.RunCycles, e.idx, e.cyc);
          chk("run_prog_idx", bus.ProgIdx, e.idx);
          chk("run_cycles", bus.RunCycles, e.cyc);
        end
      end

      if (bus.Done && !prev_done) begin
        if (exp_q.size() == 0 || exp_q[0].kind != 1) begin
          checks++;
          errors++;
          $display("FAIL unexpected_done: total=%0d, no completion expected", bus.TotalCycles);
        end else begin
          e = exp_q.pop_front();
          $display("done   prog=%0d total=%0d (expect prog=%0d total=%0d)",
                   bus.ProgIdx, bus.TotalCycles, e.idx, e.cyc);
          chk("done_prog_idx", bus.ProgIdx, e.idx);
          chk("total_cycles", bus.TotalCycles, e.cyc);
        end
      end

      if (bus.Fault && !prev_fault) begin
        if (exp_q.size() == 0 || exp_q[0].kind != 2) begin
          checks++;
          errors++;
          $display("FAIL unexpected_fault: prog=%0d, no fault expected", bus.ProgIdx);
        end else begin
          e = exp_q.pop_front();
          $display("fault  prog=%0d cycles=%0d after=%0d (expect prog=%0d cycles=%0d)",
                   bus.ProgIdx, bus.RunCycles, since, e.idx, e.cyc);
          chk("fault_prog_idx", bus.ProgIdx, e.idx);
          chk("fault_run_cycles", bus.RunCycles, e.cyc);
          chk("fault_latency", since, TIMEOUT);
        end
      end

      prev_start = bus.CoreStart;
      prev_done  = bus.Done;
      prev_fault = bus.Fault;
      prev_valid = bus.RunValid;
    end
  end

  initial begin
    int l [NPROG];
    bit s [NPROG];
    int n;
    reset     = 1'b0;
    bus.Go    = 1'b0;
    bus.Abort = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_core_start", bus.CoreStart, 0);
    chk("rst_mem_owner", bus.MemOwner, 0);
    chk("rst_busy", bus.Busy, 0);
    chk("rst_run_valid", bus.RunValid, 0);
    chk("rst_done", bus.Done, 0);
    chk("rst_fault", bus.Fault, 0);
    chk("rst_prog_idx", bus.ProgIdx, 0);
    chk("rst_run_cycles", bus.RunCycles, 0);
    chk("rst_total", bus.TotalCycles, 0);
    reset = 1'b1;
    @(negedge clk);

    // Basic sequence
    l = '{10, 5, 0};
    s = '{0, 0, 0};
    run_seq(l, s, 1'b0);
    leave_done(1'b0);

    // Stale Ack held through LAUNCH
    l = '{4, 7, 2};
    s = '{0, 1, 1};
    run_seq(l, s, 1'b0);
    leave_done(1'b1);

    // Saturating total
    l = '{200, 100, 0};
    s = '{0, 0, 0};
    run_seq(l, s, 1'b0);
    leave_done(1'b0);

    // Watchdog
    l = '{5, NEVER, 3};
    s = '{0, 0, 0};
    run_seq(l, s, 1'b0);
    chk("fault_flag", bus.Fault, 1);
    bus.Go = 1'b1;
    @(negedge clk);
    bus.Go = 1'b0;
    @(negedge clk);
    chk("fault_go_ignored", bus.Fault, 1);
    chk("fault_go_busy", bus.Busy, 0);
    chk("fault_runcycles_held", bus.RunCycles, TIMEOUT);
    bus.Abort = 1'b1;
    @(negedge clk);
    bus.Abort = 1'b0;
    chk("abort_fault_clear", bus.Fault, 0);
    chk("abort_done_clear", bus.Done, 0);
    chk("abort_busy_clear", bus.Busy, 0);
    chk("abort_owner_clear", bus.MemOwner, 0);
    job_q.delete();

    // Reset in the middle of program 1's run
    l = '{10, 30, 10};
    s = '{0, 0, 0};
    start_seq(l, s);
    n = 0;
    while (!(bus.ProgIdx == 4'd1 && bus.MemOwner && !bus.CoreStart && !bus.RunValid) && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("midrun_reached", (n < 200), 1);
    repeat (5) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("midrun_core_start", bus.CoreStart, 0);
    chk("midrun_mem_owner", bus.MemOwner, 0);
    chk("midrun_prog_idx", bus.ProgIdx, 0);
    chk("midrun_total", bus.TotalCycles, 0);
    chk("midrun_busy", bus.Busy, 0);
    reset = 1'b1;
    chk("midrun_pending", exp_q.size(), 3);
    exp_q.delete();
    job_q.delete();
    @(negedge clk);

    // Randomized sequences, some with an Abort that must be ignored mid-run
    for (int k = 0; k < 6; k++) begin
      for (int i = 0; i < NPROG; i++) begin
        l[i] = int'($urandom_range(0, 40));
        s[i] = 1'($urandom_range(0, 1));
      end
      run_seq(l, s, 1'($urandom_range(0, 1)));
      leave_done(1'($urandom_range(0, 1)));
    end

    repeat (3) @(negedge clk);
    chk("scoreboard_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
